dmux8bit_buf: RTL and testbench

DMUX8BIT_BUF -- requirements
Module: dmux8bit_buf

---
 rtl/dmux8bit_buf_pkg.sv | 17 +
 rtl/dmux8bit_buf_if.sv | 48 ++++
 rtl/dmux8bit_buf_fifo2.sv | 57 +++++
 rtl/dmux8bit_buf.sv | 85 ++++++++
 tb/tb_dmux8bit_buf.sv | 152 +++++++++++++++
 5 files changed

// File: rtl/dmux8bit_buf_pkg.sv
// Shared defaults and channel encodings for the buffered 1-to-2 byte demux.
// Imported by the interface, the fifo2 sub-module and the top level.
package dmux8bit_buf_pkg;

  localparam int WIDTH_DEF = 8;
  localparam int DEPTH_DEF = 2;

  typedef enum logic {
    CH_A = 1'b0,
    CH_B = 1'b1
  } ch_e;

  function automatic ch_e to_ch(input logic sel);
    return sel ? CH_B : CH_A;
  endfunction

endpackage

// File: rtl/dmux8bit_buf_if.sv
// Byte input stream plus the two buffered output channels.
// master drives data and consumer readys; slave is the demux.
interface dmux8bit_buf_if
  import dmux8bit_buf_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
);

  logic [WIDTH-1:0] in;
  logic             select;
  logic             inValid;
  logic             inReady;

  logic [WIDTH-1:0] outA;
  logic             outAValid;
  logic             outAReady;

  logic [WIDTH-1:0] outB;
  logic             outBValid;
  logic             outBReady;

  modport master (
    output in,
    output select,
    output inValid,
    input  inReady,
    input  outA,
    input  outAValid,
    output outAReady,
    input  outB,
    input  outBValid,
    output outBReady
  );

  modport slave (
    input  in,
    input  select,
    input  inValid,
    output inReady,
    output outA,
    output outAValid,
    input  outAReady,
    output outB,
    output outBValid,
    input  outBReady
  );

endinterface

// File: rtl/dmux8bit_buf_fifo2.sv
// Two-entry FIFO with 1-bit wrapping pointers.
// Storage is cleared on reset so nothing stale survives.
module fifo2
  import dmux8bit_buf_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [1:0]       count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [2];
  logic             wr_ptr;
  logic             rd_ptr;
  logic [1:0]       cnt;
  logic             do_push;
  logic             do_pop;

  assign full    = (cnt == 2'(DEPTH));
  assign empty   = (cnt == 2'd0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign count   = cnt;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      cnt    <= 2'd0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) begin
        rd_ptr <= ~rd_ptr;
      end
      unique case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 2'd1;
        2'b01:   cnt <= cnt - 2'd1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/dmux8bit_buf.sv
// Buffered 1-to-2 byte demux: select steers each byte into
// channel A or B, each backed by its own fifo2.
module dmux8bit_buf
  import dmux8bit_buf_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic           clk,
  input  logic           reset,
  dmux8bit_buf_if.slave  bus
);

  ch_e              sel;
  logic             ready;
  logic             push_a;
  logic             push_b;
  logic             pop_a;
  logic             pop_b;
  logic [WIDTH-1:0] dout_a;
  logic [WIDTH-1:0] dout_b;
  logic [1:0]       count_a;
  logic [1:0]       count_b;
  logic             full_a;
  logic             full_b;
  logic             empty_a;
  logic             empty_b;

  assign sel = to_ch(bus.select);

  // Readiness looks only at the selected channel's registered
  // fullness, never at the consumer readys.
  always_comb begin
    ready = 1'b0;
    unique case (sel)
      CH_A: ready = ~full_a;
      CH_B: ready = ~full_b;
      default: ready = 1'b0;
    endcase
    if (reset) ready = 1'b0;
  end

  assign bus.inReady = ready;

  assign push_a = bus.inValid & ready & (sel == CH_A);
  assign push_b = bus.inValid & ready & (sel == CH_B);
  assign pop_a  = bus.outAReady & ~empty_a;
  assign pop_b  = bus.outBReady & ~empty_b;

  fifo2 #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo_a (
    .clk   (clk),
    .reset (reset),
    .push  (push_a),
    .pop   (pop_a),
    .din   (bus.in),
    .dout  (dout_a),
    .count (count_a),
    .full  (full_a),
    .empty (empty_a)
  );

  fifo2 #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo_b (
    .clk   (clk),
    .reset (reset),
    .push  (push_b),
    .pop   (pop_b),
    .din   (bus.in),
    .dout  (dout_b),
    .count (count_b),
    .full  (full_b),
    .empty (empty_b)
  );

  assign bus.outAValid = (count_a != 2'd0);
  assign bus.outBValid = (count_b != 2'd0);
  assign bus.outA      = empty_a ? '0 : dout_a;
  assign bus.outB      = empty_b ? '0 : dout_b;

endmodule

// File: tb/tb_dmux8bit_buf.sv
// Directed bench for dmux8bit_buf: vector table plus
// hand sequences for alternation and mid-run reset.
module tb_dmux8bit_buf;

  logic clk = 1'b0;
  logic reset = 1'b1;

  always #5 clk = ~clk;

  dmux8bit_buf_if #(.WIDTH(8)) bus ();

  dmux8bit_buf #(
    .WIDTH (8),
    .DEPTH (2)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic       sel;
    logic       vld;
    logic [7:0] data;
    logic       ar;
    logic       br;
    logic       rdy;
    logic       av;
    logic [7:0] ad;
    logic       bv;
    logic [7:0] bd;
  } vec_t;

  vec_t vecs [16];
  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic sel, input logic vld,
                       input logic [7:0] d, input logic ar,
                       input logic br);
    bus.select    = sel;
    bus.inValid   = vld;
    bus.in        = d;
    bus.outAReady = ar;
    bus.outBReady = br;
  endtask

  task automatic chk_out(input string tag, input logic av,
                         input logic [7:0] ad, input logic bv,
                         input logic [7:0] bd);
    chk({tag, ".outAValid"}, 32'(bus.outAValid), 32'(av));
    chk({tag, ".outA"},      32'(bus.outA),      32'(ad));
    chk({tag, ".outBValid"}, 32'(bus.outBValid), 32'(bv));
    chk({tag, ".outB"},      32'(bus.outB),      32'(bd));
  endtask

  initial begin
    //        sel vld data  ar br rdy av ad     bv bd
    vecs[0]  = '{1, 1, 8'h12, 0, 0, 1, 0, 8'h00, 1, 8'h12};
    vecs[1]  = '{0, 0, 8'h00, 0, 1, 1, 0, 8'h00, 0, 8'h00};
    vecs[2]  = '{0, 1, 8'h98, 0, 0, 1, 1, 8'h98, 0, 8'h00};
    vecs[3]  = '{0, 1, 8'hAA, 0, 0, 1, 1, 8'h98, 0, 8'h00};
    vecs[4]  = '{0, 1, 8'h33, 0, 0, 0, 1, 8'h98, 0, 8'h00};
    vecs[5]  = '{1, 0, 8'h66, 0, 0, 1, 1, 8'h98, 0, 8'h00};
    vecs[6]  = '{0, 0, 8'h00, 1, 0, 0, 1, 8'hAA, 0, 8'h00};
    vecs[7]  = '{0, 0, 8'h00, 1, 0, 1, 0, 8'h00, 0, 8'h00};
    vecs[8]  = '{0, 0, 8'h00, 1, 1, 1, 0, 8'h00, 0, 8'h00};
    vecs[9]  = '{0, 1, 8'h55, 0, 0, 1, 1, 8'h55, 0, 8'h00};
    vecs[10] = '{0, 1, 8'h01, 1, 0, 1, 1, 8'h01, 0, 8'h00};
    vecs[11] = '{0, 1, 8'h02, 0, 0, 1, 1, 8'h01, 0, 8'h00};
    vecs[12] = '{0, 1, 8'h77, 1, 0, 0, 1, 8'h02, 0, 8'h00};
    vecs[13] = '{0, 0, 8'h00, 0, 0, 1, 1, 8'h02, 0, 8'h00};
    vecs[14] = '{1, 1, 8'h44, 1, 0, 1, 0, 8'h00, 1, 8'h44};
    vecs[15] = '{0, 0, 8'h00, 0, 1, 1, 0, 8'h00, 0, 8'h00};

    drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst.inReady", 32'(bus.inReady), 32'(0));
    chk_out("rst", 1'b0, 8'h00, 1'b0, 8'h00);

    @(negedge clk);
    reset = 1'b0;

    foreach (vecs[i]) begin
      drive(vecs[i].sel, vecs[i].vld, vecs[i].data,
            vecs[i].ar, vecs[i].br);
      #1;
      chk($sformatf("v%0d.inReady", i), 32'(bus.inReady),
          32'(vecs[i].rdy));
      @(posedge clk);
      #1;
      chk_out($sformatf("v%0d", i), vecs[i].av, vecs[i].ad,
              vecs[i].bv, vecs[i].bd);
    end

    // Alternating select with both consumers always ready.
    for (int k = 0; k < 8; k++) begin
      drive(k[0], 1'b1, 8'(k), 1'b1, 1'b1);
      #1;
      chk($sformatf("alt%0d.inReady", k), 32'(bus.inReady), 32'(1));
      @(posedge clk);
      #1;
      if (k[0])
        chk_out($sformatf("alt%0d", k), 1'b0, 8'h00, 1'b1, 8'(k));
      else
        chk_out($sformatf("alt%0d", k), 1'b1, 8'(k), 1'b0, 8'h00);
    end
    drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    @(posedge clk);
    #1;
    chk_out("alt_drain", 1'b0, 8'h00, 1'b0, 8'h00);

    // Fill both channels, then reset between clock edges.
    drive(1'b0, 1'b1, 8'hA1, 1'b0, 1'b0);
    @(posedge clk);
    #1 drive(1'b0, 1'b1, 8'hA2, 1'b0, 1'b0);
    @(posedge clk);
    #1 drive(1'b1, 1'b1, 8'hB1, 1'b0, 1'b0);
    @(posedge clk);
    #1 drive(1'b1, 1'b1, 8'hB2, 1'b0, 1'b0);
    @(posedge clk);
    #1 drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    chk_out("full", 1'b1, 8'hA1, 1'b1, 8'hB1);
    chk("full.inReadyA", 32'(bus.inReady), 32'(0));
    #1 reset = 1'b1;
    #1;
    chk_out("midrst", 1'b0, 8'h00, 1'b0, 8'h00);
    chk("midrst.inReady", 32'(bus.inReady), 32'(0));
    @(negedge clk);
    reset = 1'b0;
    drive(1'b0, 1'b1, 8'h5A, 1'b0, 1'b0);
    #1;
    chk("post.inReady", 32'(bus.inReady), 32'(1));
    @(posedge clk);
    #1;
    chk_out("post", 1'b1, 8'h5A, 1'b0, 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
